// File: rtl/down_counter.sv
// Loadable down-counter with one-shot or auto-reload terminal count.
// Emits a one-cycle borrow pulse and registered busy/done status flags.
//
// state | meaning
// IDLE  | nothing loaded (or zero loaded); count held at 0
// RUN   | counting down on en; busy high
// DONE  | one-shot expired; count held at 0, done high until next load
module down_counter #(
  parameter int N_BITS = 8
) (
  input  logic              clk,
  input  logic              syn_rst,
  input  logic              load,
  input  logic [N_BITS-1:0] load_value,
  input  logic              en,
  input  logic              auto_reload,
  output logic [N_BITS-1:0] count,
  output logic              borrow,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [N_BITS-1:0] ZERO = '0;
  localparam logic [N_BITS-1:0] ONE  = N_BITS'(1);

  state_t            state;
  logic [N_BITS-1:0] reload_reg;

  always_ff @(posedge clk) begin
    if (syn_rst) begin
      state      <= IDLE;
      count      <= ZERO;
      reload_reg <= ZERO;
      borrow     <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      borrow <= 1'b0;
      if (load) begin
        count      <= load_value;
        reload_reg <= load_value;
        done       <= 1'b0;
        if (load_value != ZERO) begin
          state <= RUN;
          busy  <= 1'b1;
        end else begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      end else begin
        case (state)
          RUN: begin
            if (en) begin
              if (count == ONE) begin
                borrow <= 1'b1;
                // reload_reg is never zero in RUN, so 0 never shows on count
                if (auto_reload) begin
                  count <= reload_reg;
                end else begin
                  count <= ZERO;
                  state <= DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                end
              end else if (count > ONE) begin
                count <= count - ONE;
              end
            end
          end
          DONE: begin
            count <= ZERO;
          end
          default: begin
            count <= ZERO;
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_down_counter.sv
// Bench for down_counter: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a behavioural model.
module tb_down_counter;

  localparam int W = 8;

  logic         clk;
  logic         syn_rst;
  logic         load;
  logic [W-1:0] load_value;
  logic         en;
  logic         auto_reload;
  logic [W-1:0] count;
  logic         borrow;
  logic         busy;
  logic         done;

  int n_cmp = 0;
  int n_bad = 0;

  down_counter #(.N_BITS(W)) dut (
    .clk         (clk),
    .syn_rst     (syn_rst),
    .load        (load),
    .load_value  (load_value),
    .en          (en),
    .auto_reload (auto_reload),
    .count       (count),
    .borrow      (borrow),
    .busy        (busy),
    .done        (done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a counter value, the value to restart from, and
  // whether it is counting or has expired.
  int m_count  = 0;
  int m_reload = 0;
  bit m_run    = 0;
  bit m_done   = 0;
  bit m_borrow = 0;

  always @(posedge clk) begin
    if (syn_rst) begin
      m_count  <= 0;
      m_reload <= 0;
      m_run    <= 0;
      m_done   <= 0;
      m_borrow <= 0;
    end else begin
      m_borrow <= 0;
      if (load) begin
        m_count  <= int'(load_value);
        m_reload <= int'(load_value);
        m_run    <= (load_value != 0);
        m_done   <= 0;
      end else if (m_run && en) begin
        if (m_count == 1) begin
          m_borrow <= 1;
          if (auto_reload) m_count <= m_reload;
          else begin
            m_count <= 0;
            m_run   <= 0;
            m_done  <= 1;
          end
        end else begin
          m_count <= m_count - 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("model_count",  32'(count),  32'(m_count));
    chk("model_borrow", 32'(borrow), 32'(m_borrow));
    chk("model_busy",   32'(busy),   32'(m_run));
    chk("model_done",   32'(done),   32'(m_done));
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk_all(input string tag, input int c, input bit b, input bit bz, input bit d);
    chk({tag, "_count"},  32'(count),  32'(c));
    chk({tag, "_borrow"}, 32'(borrow), 32'(b));
    chk({tag, "_busy"},   32'(busy),   32'(bz));
    chk({tag, "_done"},   32'(done),   32'(d));
  endtask

  initial begin
    int ens;
    int periods;
    int budget;
    int exp_seq [5];
    bit en_seq  [5];

    syn_rst = 1; load = 1; load_value = 8'h55; en = 1; auto_reload = 0;
    step();
    chk_all("reset", 0, 0, 0, 0);
    step();
    chk_all("reset2", 0, 0, 0, 0);
    syn_rst = 0; load = 0;
    step();

    // one-shot from 3
    load = 1; load_value = 8'd3; en = 1; auto_reload = 0;
    step();
    chk_all("os_load", 3, 0, 1, 0);
    load = 0;
    step(); chk_all("os_2", 2, 0, 1, 0);
    step(); chk_all("os_1", 1, 0, 1, 0);
    step(); chk_all("os_0", 0, 1, 0, 1);
    for (int i = 0; i < 10; i++) begin
      step();
      chk_all("os_hold", 0, 0, 0, 1);
    end

    // auto-reload with a stall
    load = 1; load_value = 8'd4; auto_reload = 1; en = 1;
    step();
    chk_all("ar_load", 4, 0, 1, 0);
    load = 0;
    en_seq  = '{1, 0, 1, 1, 1};
    exp_seq = '{3, 3, 2, 1, 4};
    for (int i = 0; i < 5; i++) begin
      en = en_seq[i];
      step();
      chk_all("ar_seq", exp_seq[i], (i == 4), 1, 0);
    end

    // load collides with terminal count
    en = 1;
    step(); step(); step();
    chk("coll_pre_count", 32'(count), 32'd1);
    load = 1; load_value = 8'd10;
    step();
    chk_all("coll", 10, 0, 1, 0);
    load = 0;

    // zero load parks in IDLE and ignores en
    load = 1; load_value = 8'd0;
    step();
    chk_all("zero", 0, 0, 0, 0);
    load = 0; en = 1;
    step();
    chk_all("zero_hold", 0, 0, 0, 0);

    // 255 auto-reload: borrow every 255 en cycles, en randomly stalled
    load = 1; load_value = 8'd255; auto_reload = 1;
    step();
    load = 0; load_value = 8'd7;
    ens = 0; periods = 0; budget = 0;
    while (periods < 2 && budget < 2000) begin
      en = 1'($urandom_range(0, 3) != 0);
      if (en) ens++;
      step();
      budget++;
      if (borrow) begin
        chk("period_255", 32'(ens), 32'd255);
        chk("period_reload", 32'(count), 32'd255);
        ens = 0;
        periods++;
      end
    end
    chk("period_seen", 32'(periods), 32'd2);

    // reset mid-run, then a normal short one-shot
    load = 1; load_value = 8'd20; auto_reload = 0; en = 1;
    step();
    load = 0;
    for (int i = 0; i < 5; i++) step();
    chk("mid_pre_count", 32'(count), 32'd15);
    syn_rst = 1;
    step();
    chk_all("mid_rst", 0, 0, 0, 0);
    syn_rst = 0; load = 1; load_value = 8'd2;
    step(); chk_all("post_load", 2, 0, 1, 0);
    load = 0;
    step(); chk_all("post_1", 1, 0, 1, 0);
    step(); chk_all("post_0", 0, 1, 0, 1);

    // randomized traffic, checked by the model every cycle
    for (int i = 0; i < 4000; i++) begin
      syn_rst     = ($urandom_range(0, 99) == 0);
      load        = ($urandom_range(0, 19) == 0);
      load_value  = ($urandom_range(0, 3) == 0) ? W'($urandom) : W'($urandom_range(0, 6));
      en          = 1'($urandom_range(0, 3) != 0);
      auto_reload = 1'($urandom);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
